// File: rtl/gcl_sched_if.sv
// GCL RAM read port: gcl_sched is the master, the GCL RAM the slave.
interface gcl_sched_if;
    logic         out_gcl_rd;
    logic [4:0]   out_gcl_addr;
    logic [127:0] in_gcl_rdata;

    modport master (
        output out_gcl_rd,
        output out_gcl_addr,
        input  in_gcl_rdata
    );

    modport slave (
        input  out_gcl_rd,
        input  out_gcl_addr,
        output in_gcl_rdata
    );
endinterface

// File: rtl/gcl_sched.sv
// Gate-control-list scheduler: preloads GCL words and plays them out as per-slot gate vectors.
// Define GCL_SCHED_GUARD_EN to close gates early in a guard band at the end of each slot.
module gcl_sched #(
    parameter int unsigned RD_LAT    = 1,
    parameter logic [7:0]  GATE_IDLE = 8'hFF,
    parameter int unsigned GUARD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_test_start,
    input  logic [19:0] in_slot_cycle,
    gcl_sched_if.master gcl,
    output logic [7:0]  out_gate,
    output logic [8:0]  out_slot_id,
    output logic        out_slot_shift,
    output logic        out_period_start,
    output logic        out_running
);

    typedef enum logic [1:0] {StIdle, StPre0, StPre1, StRun} state_e;

    localparam logic [2:0]  RdLat    = 3'(RD_LAT);
    localparam logic [19:0] GuardCyc = 20'(GUARD_CYC);

    state_e       state_q, state_d;
    logic [19:0]  cyc_q, cyc_d;
    logic [19:0]  cnt_q, cnt_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] nxt_q, nxt_d;
    logic [2:0]   lat_q, lat_d;
    logic         pf_q, pf_d;
    logic         rd_q, rd_d;
    logic [4:0]   addr_q, addr_d;
    logic [7:0]   gate_q, gate_d;
    logic [8:0]   id_q, id_d;
    logic         shift_q, shift_d;
    logic         pstart_q, pstart_d;
    logic         running_q, running_d;

    logic         rdata_ok;
    logic [8:0]   id_inc;
    logic [7:0]   cur_byte;
    logic [7:0]   next_byte;
    logic [7:0]   guard_gate;
    logic [19:0]  guard_len;
    logic         guard_on;

    // lat_q counts down from RD_LAT after a read; 1 marks the cycle rdata is valid.
    assign rdata_ok  = (lat_q == 3'd1);
    assign id_inc    = id_q + 9'd1;
    assign cur_byte  = cur_q[{id_q[3:0], 3'b000} +: 8];
    assign next_byte = (id_q[3:0] == 4'hF) ? nxt_q[7:0] : cur_q[{id_inc[3:0], 3'b000} +: 8];

    always_comb begin
        guard_len = (GuardCyc < cyc_q - 20'd1) ? GuardCyc : cyc_q - 20'd1;
        guard_on  = (cnt_q + 20'd1) >= (cyc_q - guard_len);
    end

`ifdef GCL_SCHED_GUARD_EN
    assign guard_gate = cur_byte & next_byte;
`else
    assign guard_gate = cur_byte;
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        lat_d     = (lat_q != 3'd0) ? lat_q - 3'd1 : 3'd0;
        pf_d      = 1'b0;
        rd_d      = 1'b0;
        addr_d    = addr_q;
        gate_d    = gate_q;
        id_d      = id_q;
        shift_d   = 1'b0;
        pstart_d  = 1'b0;
        running_d = running_q;

        if (rd_q) begin
            lat_d = RdLat;
        end

        // Stop has priority over any slot boundary or read return in the same cycle.
        if (state_q != StIdle && !in_test_start) begin
            state_d   = StIdle;
            cnt_d     = 20'd0;
            lat_d     = 3'd0;
            addr_d    = 5'd0;
            gate_d    = GATE_IDLE;
            id_d      = 9'd0;
            running_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_test_start) begin
                        state_d = StPre0;
                        cyc_d   = (in_slot_cycle < 20'd2) ? 20'd2 : in_slot_cycle;
                        rd_d    = 1'b1;
                        addr_d  = 5'd0;
                    end
                end
                StPre0: begin
                    if (rdata_ok) begin
                        cur_d   = gcl.in_gcl_rdata;
                        state_d = StPre1;
                        rd_d    = 1'b1;
                        addr_d  = 5'd1;
                    end
                end
                StPre1: begin
                    if (rdata_ok) begin
                        nxt_d     = gcl.in_gcl_rdata;
                        state_d   = StRun;
                        gate_d    = cur_q[7:0];
                        id_d      = 9'd0;
                        cnt_d     = 20'd0;
                        running_d = 1'b1;
                        pstart_d  = 1'b1;
                    end
                end
                StRun: begin
                    if (rdata_ok) begin
                        nxt_d = gcl.in_gcl_rdata;
                    end
                    // One cycle after a word crossing, fetch the word after the new one.
                    if (pf_q) begin
                        rd_d   = 1'b1;
                        addr_d = id_q[8:4] + 5'd1;
                    end
                    if (cnt_q == cyc_q - 20'd1) begin
                        cnt_d    = 20'd0;
                        id_d     = id_inc;
                        shift_d  = 1'b1;
                        gate_d   = next_byte;
                        pstart_d = (id_inc == 9'd0);
                        if (id_inc[3:0] == 4'h0) begin
                            cur_d = nxt_q;
                            pf_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                        if (guard_on) begin
                            gate_d = guard_gate;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cyc_q     <= 20'd0;
            cnt_q     <= 20'd0;
            cur_q     <= '0;
            nxt_q     <= '0;
            lat_q     <= 3'd0;
            pf_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 5'd0;
            gate_q    <= GATE_IDLE;
            id_q      <= 9'd0;
            shift_q   <= 1'b0;
            pstart_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            lat_q     <= lat_d;
            pf_q      <= pf_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            gate_q    <= gate_d;
            id_q      <= id_d;
            shift_q   <= shift_d;
            pstart_q  <= pstart_d;
            running_q <= running_d;
        end
    end

    assign gcl.out_gcl_rd   = rd_q;
    assign gcl.out_gcl_addr = addr_q;
    assign out_gate         = gate_q;
    assign out_slot_id      = id_q;
    assign out_slot_shift   = shift_q;
    assign out_period_start = pstart_q;
    assign out_running      = running_q;

endmodule
